// File: rtl/rf_wb_if.sv
// Bundles the writeback scheduler's pipeline-facing signals: ALU/JAL writes,
// the load issue/return path, hazard query and the register-file write port.
interface rf_wb_if #(
  parameter int N = 32
);
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic         jal_valid;
  logic [4:0]   jal_rd;
  logic         ext_issue;
  logic [4:0]   ext_issue_rd;
  logic         ext_valid;
  logic         ext_ready;
  logic [4:0]   ext_rd;
  logic [N-1:0] ext_data;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         stall;
  logic [2:0]   write_sel;
  logic [4:0]   wr_rd;
  logic [N-1:0] ext_wdata;
  logic         proto_err;

  modport master (
    output alu_valid, alu_rd, jal_valid, jal_rd, ext_issue, ext_issue_rd,
           ext_valid, ext_rd, ext_data, rs1, rs2,
    input  ext_ready, stall, write_sel, wr_rd, ext_wdata, proto_err
  );

  modport slave (
    input  alu_valid, alu_rd, jal_valid, jal_rd, ext_issue, ext_issue_rd,
           ext_valid, ext_rd, ext_data, rs1, rs2,
    output ext_ready, stall, write_sel, wr_rd, ext_wdata, proto_err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Shares the register-file write port between ALU, JAL and buffered load data,
// and tracks outstanding loads in a per-register pending scoreboard.
module rf_wb_scheduler #(
  parameter int N          = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic   clk,
  input logic   n_reset,
  rf_wb_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [N-1:0] data_mem [FIFO_DEPTH];
  logic [4:0]   rd_mem   [FIFO_DEPTH];

  logic [PW:0]  wr_ptr_reg, wr_ptr_next;
  logic [PW:0]  rd_ptr_reg, rd_ptr_next;
  logic [31:0]  pending_reg, pending_next;
  logic         proto_err_reg, proto_err_next;

  logic         empty, full, ready, push, pop;
  logic         alu_wr, jal_wr;
  logic [4:0]   head_rd;

  always_comb begin
    empty   = (wr_ptr_reg == rd_ptr_reg);
    full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
              (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    head_rd = rd_mem[rd_ptr_reg[PW-1:0]];

    // A write to x0 leaves the port free for the FIFO; a JAL behind an ALU write is dropped.
    alu_wr  = bus.alu_valid && (bus.alu_rd != 5'd0);
    jal_wr  = !bus.alu_valid && bus.jal_valid && (bus.jal_rd != 5'd0);
    pop     = n_reset && !empty && !alu_wr && !jal_wr;
    ready   = n_reset && !full;
    push    = bus.ext_valid && ready;

    wr_ptr_next = wr_ptr_reg + {{PW{1'b0}}, push};
    rd_ptr_next = rd_ptr_reg + {{PW{1'b0}}, pop};

    proto_err_next = proto_err_reg
                   | (bus.alu_valid && bus.jal_valid)
                   | (bus.ext_valid && !ready)
                   | (alu_wr && pending_reg[bus.alu_rd])
                   | (jal_wr && pending_reg[bus.jal_rd]);

    bus.write_sel = 3'b000;
    bus.wr_rd     = 5'd0;
    if (n_reset) begin
      if (alu_wr) begin
        bus.write_sel = 3'b001;
        bus.wr_rd     = bus.alu_rd;
      end else if (jal_wr) begin
        bus.write_sel = 3'b010;
        bus.wr_rd     = bus.jal_rd;
      end else if (pop && (head_rd != 5'd0)) begin
        bus.write_sel = 3'b100;
        bus.wr_rd     = head_rd;
      end
    end

    bus.ext_ready = ready;
    bus.ext_wdata = data_mem[rd_ptr_reg[PW-1:0]];
    bus.proto_err = proto_err_reg;
    bus.stall     = n_reset &&
                    (((bus.rs1 != 5'd0) && pending_reg[bus.rs1]) ||
                     ((bus.rs2 != 5'd0) && pending_reg[bus.rs2]));
  end

  // Set beats clear: a re-issued load to the same register is still outstanding.
  assign pending_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_pending
    assign pending_next[gi] = (bus.ext_issue && (bus.ext_issue_rd == 5'(gi))) ||
                              (pending_reg[gi] && !(pop && (head_rd == 5'(gi))));
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      pending_reg   <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      pending_reg   <= pending_next;
      proto_err_reg <= proto_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg[PW-1:0]] <= bus.ext_data;
      rd_mem[wr_ptr_reg[PW-1:0]]   <= bus.ext_rd;
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// model of the writeback scheduler.
module tb_rf_wb_scheduler;
  localparam int N = 32;
  localparam int D = 2;

  typedef struct packed {
    logic [4:0]   rd;
    logic [N-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  rf_wb_if #(.N(N)) bus();
  rf_wb_scheduler #(.N(N), .FIFO_DEPTH(D)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.jal_valid = 0; bus.jal_rd = 0;
    bus.ext_issue = 0; bus.ext_issue_rd = 0; bus.ext_valid = 0; bus.ext_rd = 0;
    bus.ext_data = 0; bus.rs1 = 0; bus.rs2 = 0;
  endtask

  task automatic do_reset();
    n_reset = 0;
    idle();
    tick();
    tick();
    n_reset = 1;
  endtask

  task automatic test_reset();
    idle();
    n_reset = 0;
    bus.alu_valid = 1; bus.alu_rd = 5; bus.ext_valid = 1; bus.rs1 = 5;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b000) begin n_err++; $display("FAIL rst_sel: got %b want 000", bus.write_sel); end
    n_cmp++; if (bus.ext_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.ext_ready); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    tick();
    idle();
    n_reset = 1;
    bus.rs1 = 5;
    @(negedge clk);
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.proto_err); end
    n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", bus.ext_ready); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_after: got %b want 0", bus.stall); end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    do_reset();
    bus.alu_valid = 1; bus.alu_rd = 5;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b001) begin n_err++; $display("FAIL alu_sel: got %b want 001", bus.write_sel); end
    n_cmp++; if (bus.wr_rd !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d want 5", bus.wr_rd); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", bus.stall); end
    tick();
    idle();
    bus.jal_valid = 1; bus.jal_rd = 11;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b010) begin n_err++; $display("FAIL jal_sel: got %b want 010", bus.write_sel); end
    n_cmp++; if (bus.wr_rd !== 5'd11) begin n_err++; $display("FAIL jal_rd: got %0d want 11", bus.wr_rd); end
    tick();
    idle();
    $display("test_alu done");
  endtask

  task automatic test_load_stall();
    do_reset();
    bus.ext_issue = 1; bus.ext_issue_rd = 7;
    tick();
    bus.ext_issue = 0; bus.rs1 = 7;
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL ld_stall_set: got %b want 1", bus.stall); end
    bus.ext_valid = 1; bus.ext_rd = 7; bus.ext_data = 32'hDEADBEEF;
    tick();
    bus.ext_valid = 0;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b100) begin n_err++; $display("FAIL ld_sel: got %b want 100", bus.write_sel); end
    n_cmp++; if (bus.wr_rd !== 5'd7) begin n_err++; $display("FAIL ld_rd: got %0d want 7", bus.wr_rd); end
    n_cmp++; if (bus.ext_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_data: got %h want deadbeef", bus.ext_wdata); end
    n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL ld_stall_hold: got %b want 1", bus.stall); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL ld_stall_clr: got %b want 0", bus.stall); end
    n_cmp++; if (bus.write_sel !== 3'b000) begin n_err++; $display("FAIL ld_idle: got %b want 000", bus.write_sel); end
    $display("test_load_stall done");
  endtask

  task automatic test_fifo_order();
    do_reset();
    bus.alu_valid = 1; bus.alu_rd = 1;
    bus.ext_valid = 1; bus.ext_rd = 3; bus.ext_data = 32'hAAAA0003;
    tick();
    bus.ext_rd = 4; bus.ext_data = 32'hBBBB0004;
    tick();
    bus.ext_valid = 0;
    @(negedge clk);
    n_cmp++; if (bus.ext_ready !== 1'b0) begin n_err++; $display("FAIL fo_full: got %b want 0", bus.ext_ready); end
    n_cmp++; if (bus.write_sel !== 3'b001) begin n_err++; $display("FAIL fo_busy: got %b want 001", bus.write_sel); end
    tick();
    bus.alu_valid = 0;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b100 || bus.wr_rd !== 5'd3) begin n_err++; $display("FAIL fo_first: got sel %b rd %0d want 100/3", bus.write_sel, bus.wr_rd); end
    n_cmp++; if (bus.ext_wdata !== 32'hAAAA0003) begin n_err++; $display("FAIL fo_first_data: got %h want aaaa0003", bus.ext_wdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b100 || bus.wr_rd !== 5'd4) begin n_err++; $display("FAIL fo_second: got sel %b rd %0d want 100/4", bus.write_sel, bus.wr_rd); end
    n_cmp++; if (bus.ext_wdata !== 32'hBBBB0004) begin n_err++; $display("FAIL fo_second_data: got %h want bbbb0004", bus.ext_wdata); end
    n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL fo_ready_back: got %b want 1", bus.ext_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b000 || bus.wr_rd !== 5'd0) begin n_err++; $display("FAIL fo_drained: got sel %b rd %0d want 000/0", bus.write_sel, bus.wr_rd); end
    $display("test_fifo_order done");
  endtask

  task automatic test_overflow();
    do_reset();
    bus.alu_valid = 1; bus.alu_rd = 2;
    bus.ext_valid = 1; bus.ext_rd = 20; bus.ext_data = 32'h00000020;
    tick();
    bus.ext_rd = 21; bus.ext_data = 32'h00000021;
    tick();
    bus.ext_rd = 22; bus.ext_data = 32'h00000022;
    @(negedge clk);
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL ov_err_before: got %b want 0", bus.proto_err); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL ov_err_set: got %b want 1", bus.proto_err); end
    n_cmp++; if (bus.wr_rd !== 5'd20 || bus.ext_wdata !== 32'h20) begin n_err++; $display("FAIL ov_head0: got rd %0d data %h want 20/20", bus.wr_rd, bus.ext_wdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.wr_rd !== 5'd21 || bus.ext_wdata !== 32'h21) begin n_err++; $display("FAIL ov_head1: got rd %0d data %h want 21/21", bus.wr_rd, bus.ext_wdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b000) begin n_err++; $display("FAIL ov_dropped: got %b want 000", bus.write_sel); end
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL ov_err_sticky: got %b want 1", bus.proto_err); end
    n_reset = 0;
    tick();
    n_reset = 1;
    @(negedge clk);
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL ov_err_cleared: got %b want 0", bus.proto_err); end
    $display("test_overflow done");
  endtask

  task automatic test_dual_valid();
    do_reset();
    bus.alu_valid = 1; bus.alu_rd = 9; bus.jal_valid = 1; bus.jal_rd = 10;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b001 || bus.wr_rd !== 5'd9) begin n_err++; $display("FAIL dv_sel: got sel %b rd %0d want 001/9", bus.write_sel, bus.wr_rd); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL dv_err: got %b want 1", bus.proto_err); end
    do_reset();
    bus.ext_valid = 1; bus.ext_rd = 6; bus.ext_data = 32'hC0FFEE06;
    tick();
    bus.ext_valid = 0; bus.alu_valid = 1; bus.alu_rd = 0;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b100 || bus.wr_rd !== 5'd6) begin n_err++; $display("FAIL x0_drain: got sel %b rd %0d want 100/6", bus.write_sel, bus.wr_rd); end
    n_cmp++; if (bus.ext_wdata !== 32'hC0FFEE06) begin n_err++; $display("FAIL x0_data: got %h want c0ffee06", bus.ext_wdata); end
    tick();
    idle();
    $display("test_dual_valid done");
  endtask

  task automatic test_set_clear();
    do_reset();
    bus.ext_issue = 1; bus.ext_issue_rd = 12;
    tick();
    bus.ext_issue = 0; bus.ext_valid = 1; bus.ext_rd = 12; bus.ext_data = 32'h1234;
    tick();
    bus.ext_valid = 0; bus.ext_issue = 1; bus.ext_issue_rd = 12; bus.rs1 = 12;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b100 || bus.wr_rd !== 5'd12) begin n_err++; $display("FAIL sc_pop: got sel %b rd %0d want 100/12", bus.write_sel, bus.wr_rd); end
    tick();
    bus.ext_issue = 0;
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL sc_set_wins: got %b want 1", bus.stall); end
    bus.alu_valid = 1; bus.alu_rd = 12;
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL sc_waw: got %b want 1", bus.proto_err); end
    $display("test_set_clear done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.alu_valid = 1; bus.alu_rd = 1;
    bus.ext_valid = 1; bus.ext_rd = 13; bus.ext_data = 32'h13;
    bus.ext_issue = 1; bus.ext_issue_rd = 13;
    tick();
    idle();
    bus.rs1 = 13;
    n_reset = 0;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b000 || bus.stall !== 1'b0 || bus.ext_ready !== 1'b0) begin n_err++; $display("FAIL rm_forced: got sel %b stall %b ready %b want 000/0/0", bus.write_sel, bus.stall, bus.ext_ready); end
    tick();
    n_reset = 1;
    @(negedge clk);
    n_cmp++; if (bus.write_sel !== 3'b000 || bus.stall !== 1'b0 || bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL rm_after: got sel %b stall %b ready %b want 000/0/1", bus.write_sel, bus.stall, bus.ext_ready); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random(input bit legal, input int cycles);
    ent_t q[$];
    bit pend[32];
    bit err;
    bit do_pop, eready, estall, nerr;
    logic [2:0] esel;
    logic [4:0] erd;
    ent_t e;
    do_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    err = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.alu_valid = ($urandom_range(0, 9) < 3); bus.alu_rd = 5'($urandom_range(0, 31));
      bus.jal_valid = ($urandom_range(0, 9) < 2); bus.jal_rd = 5'($urandom_range(0, 31));
      bus.ext_issue = ($urandom_range(0, 9) < 3); bus.ext_issue_rd = 5'($urandom_range(0, 31));
      bus.ext_valid = ($urandom_range(0, 9) < 4); bus.ext_rd = 5'($urandom_range(0, 31));
      bus.ext_data = $urandom; bus.rs1 = 5'($urandom_range(0, 31)); bus.rs2 = 5'($urandom_range(0, 31));
      if (legal) begin
        if (bus.alu_valid) bus.jal_valid = 0;
        if (bus.alu_valid && pend[bus.alu_rd]) bus.alu_valid = 0;
        if (bus.jal_valid && pend[bus.jal_rd]) bus.jal_valid = 0;
        if (q.size() >= D) bus.ext_valid = 0;
      end
      @(negedge clk);
      esel = 3'b000; erd = 5'd0;
      if (bus.alu_valid) begin
        if (bus.alu_rd != 0) begin esel = 3'b001; erd = bus.alu_rd; end
      end else if (bus.jal_valid && bus.jal_rd != 0) begin
        esel = 3'b010; erd = bus.jal_rd;
      end
      eready = (q.size() < D);
      do_pop = (esel == 3'b000) && (q.size() > 0);
      if (do_pop && q[0].rd != 0) begin esel = 3'b100; erd = q[0].rd; end
      estall = (bus.rs1 != 0 && pend[bus.rs1]) || (bus.rs2 != 0 && pend[bus.rs2]);
      n_cmp++; if (bus.write_sel !== esel || bus.wr_rd !== erd) begin n_err++; $display("FAIL rnd_port c%0d: got sel %b rd %0d want %b/%0d", c, bus.write_sel, bus.wr_rd, esel, erd); end
      n_cmp++; if (bus.ext_ready !== eready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.ext_ready, eready); end
      n_cmp++; if (bus.stall !== estall) begin n_err++; $display("FAIL rnd_stall c%0d: got %b want %b", c, bus.stall, estall); end
      n_cmp++; if (bus.proto_err !== err) begin n_err++; $display("FAIL rnd_err c%0d: got %b want %b", c, bus.proto_err, err); end
      if (q.size() > 0) begin
        n_cmp++; if (bus.ext_wdata !== q[0].d) begin n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, bus.ext_wdata, q[0].d); end
      end
      nerr = (bus.alu_valid && bus.jal_valid) || (bus.ext_valid && !eready) ||
             (esel == 3'b001 && pend[bus.alu_rd]) || (esel == 3'b010 && pend[bus.jal_rd]);
      err = err | nerr;
      if (do_pop) begin
        e = q.pop_front();
        if (e.rd != 0) pend[e.rd] = 0;
      end
      if (bus.ext_valid && eready) q.push_back('{rd: bus.ext_rd, d: bus.ext_data});
      if (bus.ext_issue && bus.ext_issue_rd != 0) pend[bus.ext_issue_rd] = 1;
      tick();
    end
    idle();
    $display("test_random legal=%0d done", legal);
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_load_stall();
    test_fifo_order();
    test_overflow();
    test_dual_valid();
    test_set_clear();
    test_reset_mid();
    test_random(1'b1, 400);
    test_random(1'b0, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
